// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder of the 8-bit core:
//   - state_t     : responder FSM states (IDLE, WAIT, RESP)
//   - LATENCY_MIN / LATENCY_MAX : legal access latency range
//   - CNT_W       : width of the latency down-counter
//   - CORE_DATA_W / CORE_ADDR_W : native data/address widths of the core
//   - req_t       : request record captured on acceptance (we, addr, wdata)
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 7;
    localparam int CNT_W       = 3;

    localparam int CORE_DATA_W = 8;
    localparam int CORE_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                   we;
        logic [CORE_ADDR_W-1:0] addr;
        logic [CORE_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the core's memory port and the responder.
//   req_valid, req_we, req_addr, req_wdata : request from the core
//   req_ready                              : responder can accept this cycle
//   rsp_valid, rsp_rdata, rsp_err          : completion pulse and its data
// Modports:
//   master : the core side (drives requests)
//   slave  : the responder side (drives ready and responses)
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x DATA_W storage for the data-memory responder. No reset: contents
// are undefined until written.
//   clk   : write clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : combinational read data (mem[raddr])
// -----------------------------------------------------------------------------
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the 8-bit core. A request is latched on
// acceptance, held for LATENCY cycles, then the array is accessed and a
// one-cycle rsp_valid pulse returns the result. req_ready low stalls the core.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : dmem_responder_if.slave (request in, ready/response out)
// Parameters:
//   DATA_W, ADDR_W : widths (match the core's native widths)
//   DEPTH          : implemented words; addresses >= DEPTH complete with error
//   LATENCY        : cycles from acceptance to response, 1..7
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = CORE_DATA_W,
    parameter int ADDR_W  = CORE_ADDR_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    // Out-of-range LATENCY values are pulled into the legal range so the
    // counter load always fits in CNT_W bits.
    localparam int LAT_EFF = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                             (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

    // Index width just large enough to address DEPTH words.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    req_t              lat_req_reg;
    logic              req_ready_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;

    // Views of the latched request at the responder's own widths.
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_we;
    logic              addr_in_range;
    logic              access_now;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_idx;
    logic [DATA_W-1:0] arr_rdata;

    assign acc_addr      = lat_req_reg.addr;
    assign acc_wdata     = lat_req_reg.wdata;
    assign acc_we        = lat_req_reg.we;
    assign addr_in_range = (32'(acc_addr) < 32'(DEPTH));

    // The access happens on the edge that leaves WAIT with the counter at 0.
    assign access_now    = (state_reg == WAIT) && (cnt_reg == '0);
    assign arr_we        = access_now && acc_we && addr_in_range;
    assign arr_idx       = acc_addr[IDX_W-1:0];

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_idx),
        .wdata (acc_wdata),
        .raddr (arr_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            lat_req_reg   <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                // RESP accepts exactly like IDLE; the accepting edge is also
                // the one that ends the response pulse.
                IDLE, RESP: begin
                    rsp_valid_reg <= 1'b0;
                    if (bus.req_valid) begin
                        lat_req_reg   <= '{we:    bus.req_we,
                                           addr:  bus.req_addr,
                                           wdata: bus.req_wdata};
                        cnt_reg       <= CNT_LOAD;
                        req_ready_reg <= 1'b0;
                        state_reg     <= WAIT;
                    end else begin
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        rsp_valid_reg <= 1'b1;
                        req_ready_reg <= 1'b1;
                        rsp_err_reg   <= !addr_in_range;
                        if (!addr_in_range) begin
                            rsp_rdata_reg <= '0;
                        end else if (acc_we) begin
                            rsp_rdata_reg <= acc_wdata;
                        end else begin
                            rsp_rdata_reg <= arr_rdata;
                        end
                        state_reg <= RESP;
                    end
                end

                default: begin
                    rsp_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b1;
                    cnt_reg       <= '0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Five responders with different
// LATENCY/DEPTH share one clock, one reset and one request data bus; only the
// instance selected by 'sel' sees req_valid.
//   inst 0: LATENCY=3 DEPTH=256   inst 1: LATENCY=2 DEPTH=256
//   inst 2: LATENCY=1 DEPTH=256   inst 3: LATENCY=7 DEPTH=256
//   inst 4: LATENCY=2 DEPTH=16
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int NINST = 5;

    function automatic int lat_of(input int i);
        case (i)
            0: return 3;
            1: return 2;
            2: return 1;
            3: return 7;
            default: return 2;
        endcase
    endfunction

    function automatic int depth_of(input int i);
        return (i == 4) ? 16 : 256;
    endfunction

    logic       clk = 1'b0;
    logic       rst_n;
    int         sel;
    logic       req_valid;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;

    logic [NINST-1:0] ready_a;
    logic [NINST-1:0] rvalid_a;
    logic [NINST-1:0] err_a;
    logic [7:0]       rdata_a [NINST];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
        dmem_responder_if #(.DATA_W(8), .ADDR_W(8)) bus ();

        assign bus.req_valid = req_valid && (sel == gi);
        assign bus.req_we    = req_we;
        assign bus.req_addr  = req_addr;
        assign bus.req_wdata = req_wdata;

        assign ready_a[gi]  = bus.req_ready;
        assign rvalid_a[gi] = bus.rsp_valid;
        assign err_a[gi]    = bus.rsp_err;
        assign rdata_a[gi]  = bus.rsp_rdata;

        dmem_responder #(
            .DATA_W  (8),
            .ADDR_W  (8),
            .DEPTH   (depth_of(gi)),
            .LATENCY (lat_of(gi))
        ) u_dut (
            .clk (clk),
            .rst (rst_n),
            .bus (bus)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One complete request on instance idx starting from an idle responder:
    // checks acceptance, silence during WAIT, the pulse exactly lat cycles
    // after acceptance, the returned data/error, and the pulse ending.
    task automatic request(input string tag, input int idx, input logic we,
                           input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] exp_rdata, input logic exp_err);
        int   lat;
        logic noisy;
        lat   = lat_of(idx);
        noisy = 1'b0;
        check({tag, "_ready_before"}, ready_a[idx], 1'b1);
        sel       = idx;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            req_wdata = ~req_wdata;   // must be ignored while waiting
            tick();
            if (k < lat) begin
                noisy = noisy | rvalid_a[idx] | ready_a[idx];
            end
        end
        if (lat > 1) check({tag, "_wait_quiet"}, noisy, 1'b0);
        check({tag, "_valid_at_lat"}, rvalid_a[idx], 1'b1);
        check({tag, "_rdata"}, rdata_a[idx], exp_rdata);
        check({tag, "_err"}, err_a[idx], exp_err);
        $display("txn inst%0d %s addr=0x%02h wdata=0x%02h -> rdata=0x%02h err=%0d",
                 idx, we ? "WR" : "RD", addr, wdata, rdata_a[idx], err_a[idx]);
        tick();
        check({tag, "_valid_one_cycle"}, rvalid_a[idx], 1'b0);
        check({tag, "_ready_after"}, ready_a[idx], 1'b1);
    endtask

    initial begin
        logic noisy;
        sel       = 0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        tick();
        tick();

        // Reset state of every instance.
        for (int i = 0; i < NINST; i++) begin
            check($sformatf("reset_ready%0d", i), ready_a[i], 1'b1);
            check($sformatf("reset_valid%0d", i), rvalid_a[i], 1'b0);
            check($sformatf("reset_rdata%0d", i), rdata_a[i], 8'h00);
            check($sformatf("reset_err%0d", i), err_a[i], 1'b0);
        end
        rst_n = 1'b1;

        // Reset mid-WAIT (LATENCY=3): setup 0x11 at 0x10, then drop a 0x5A write.
        request("setup_w10", 0, 1'b1, 8'h10, 8'h11, 8'h11, 1'b0);
        sel       = 0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h10;
        req_wdata = 8'h5A;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready_a[0], 1'b1);
        check("midrst_valid", rvalid_a[0], 1'b0);
        check("midrst_rdata", rdata_a[0], 8'h00);
        noisy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) rst_n = 1'b1;
            tick();
            noisy = noisy | rvalid_a[0];
        end
        check("midrst_no_rsp", noisy, 1'b0);
        $display("txn inst0 WR addr=0x10 wdata=0x5a dropped by reset");
        request("midrst_read", 0, 1'b0, 8'h10, 8'h00, 8'h11, 1'b0);

        // Basic write/read with LATENCY=2.
        request("basic_w", 1, 1'b1, 8'h03, 8'hA5, 8'hA5, 1'b0);
        request("basic_r", 1, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0);

        // Back-to-back with LATENCY=1, req_valid held high for 4 requests.
        sel       = 2;
        req_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            req_we    = (r < 2);
            req_addr  = 8'(r % 2);
            req_wdata = 8'(r + 1);
            check($sformatf("b2b%0d_ready_hi", r), ready_a[2], 1'b1);
            tick();
            check($sformatf("b2b%0d_ready_lo", r), ready_a[2], 1'b0);
            check($sformatf("b2b%0d_valid_lo", r), rvalid_a[2], 1'b0);
            tick();
            check($sformatf("b2b%0d_valid", r), rvalid_a[2], 1'b1);
            check($sformatf("b2b%0d_rdata", r), rdata_a[2], 8'((r % 2) + 1));
            check($sformatf("b2b%0d_err", r), err_a[2], 1'b0);
            $display("txn inst2 b2b#%0d rdata=0x%02h err=%0d", r, rdata_a[2], err_a[2]);
        end
        req_valid = 1'b0;
        tick();
        check("b2b_end_valid", rvalid_a[2], 1'b0);
        check("b2b_end_ready", ready_a[2], 1'b1);

        // Out of range with DEPTH=16.
        request("oor_base", 4, 1'b1, 8'h00, 8'h33, 8'h33, 1'b0);
        request("oor_w", 4, 1'b1, 8'h20, 8'hFF, 8'h00, 1'b1);
        request("oor_r", 4, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1);
        request("oor_alias", 4, 1'b0, 8'h00, 8'h00, 8'h33, 1'b0);

        // Latency extremes and address boundaries.
        request("l1_w00", 2, 1'b1, 8'h00, 8'h3C, 8'h3C, 1'b0);
        request("l1_r00", 2, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0);
        request("l1_wff", 2, 1'b1, 8'hFF, 8'hC3, 8'hC3, 1'b0);
        request("l1_rff", 2, 1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0);
        request("l7_w00", 3, 1'b1, 8'h00, 8'h96, 8'h96, 1'b0);
        request("l7_r00", 3, 1'b0, 8'h00, 8'h00, 8'h96, 1'b0);
        request("l7_wff", 3, 1'b1, 8'hFF, 8'h69, 8'h69, 1'b0);
        request("l7_rff", 3, 1'b0, 8'hFF, 8'h00, 8'h69, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
